// File: rtl/core_defines_pkg.sv
// Shared definitions for the pipeline flow controller: bus-wait FSM encodings
// and default sizing parameters.
package core_defines;

  localparam int REG_AW_DEF      = 5;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int BUS_TIMEOUT_DEF = 255;

  typedef enum logic {
    FC_IDLE = 1'b0,
    FC_WAIT = 1'b1
  } fc_state_e;

endpackage

// File: rtl/flow_ctrl_bus_wait.sv
// Data-bus wait-state tracker: holds the pipeline while MEM waits for an ack,
// and abandons the access after BUS_TIMEOUT wait cycles.
module fc_bus_wait
  import core_defines::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_req,
  input  logic i_mem_ack,
  output logic o_mem_stall,
  output logic o_timeout,
  output logic o_bus_err
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fc_state_e     r_state;
  fc_state_e     w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_nxt;
  logic          r_bus_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FC_IDLE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_bus_err  <= o_timeout;
    end
  end

  // Once in WAIT the access is assumed held by MEM, so only ack or timeout exit.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    o_mem_stall    = 1'b0;
    o_timeout      = 1'b0;
    case (r_state)
      FC_IDLE: begin
        if (i_mem_req && !i_mem_ack) begin
          w_state_nxt    = FC_WAIT;
          w_wait_cnt_nxt = CNT_ONE;
          o_mem_stall    = 1'b1;
        end
      end
      FC_WAIT: begin
        if (i_mem_ack) begin
          w_state_nxt    = FC_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == CNT_MAX) begin
          w_state_nxt    = FC_IDLE;
          w_wait_cnt_nxt = '0;
          o_timeout      = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
          o_mem_stall    = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = FC_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  assign o_bus_err = r_bus_err;

endmodule

// File: rtl/flow_ctrl.sv
// Central pipeline flow controller: turns bus waits, divides, taken jumps and
// load-use hazards into per-register block/flush strobes.
module flow_ctrl
  import core_defines::*;
#(
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_raddr_i,
  input  logic              id_rs1_re_i,
  input  logic [REG_AW-1:0] id_rs2_raddr_i,
  input  logic              id_rs2_re_i,
  input  logic              idex_mem_re_i,
  input  logic [REG_AW-1:0] idex_reg_waddr_i,
  input  logic              ex_jump_i,
  input  logic              ex_div_start_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              fc_bk_pc_o,
  output logic              fc_bk_ifid_o,
  output logic              fc_bk_idex_o,
  output logic              fc_bk_exmem_o,
  output logic              fc_bk_memwb_o,
  output logic              fc_flush_ifid_o,
  output logic              fc_flush_idex_o,
  output logic              fc_flush_exmem_o,
  output logic              fc_flush_memwb_o,
  output logic              fc_div_busy_o,
  output logic              fc_bus_err_o
);

  localparam int DCW = $clog2(DIV_CYCLES);
  localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

  logic           w_mem_stall;
  logic           w_timeout;
  logic           w_div_start;
  logic           w_div_stall;
  logic           w_load_use;
  logic           w_rs1_hit;
  logic           w_rs2_hit;
  logic [DCW-1:0] r_div_cnt;
  logic           r_div_done;

  fc_bus_wait #(
    .BUS_TIMEOUT (BUS_TIMEOUT)
  ) u_bus_wait (
    .clk         (clk),
    .rst         (rst),
    .i_mem_req   (mem_req_i),
    .i_mem_ack   (mem_ack_i),
    .o_mem_stall (w_mem_stall),
    .o_timeout   (w_timeout),
    .o_bus_err   (fc_bus_err_o)
  );

  // The start level stays high while the divide sits in EX; the done flag stops
  // it re-triggering until the instruction actually leaves EX.
  assign w_div_start   = ex_div_start_i && (r_div_cnt == '0) && !r_div_done;
  assign w_div_stall   = w_div_start || (r_div_cnt != '0);
  assign fc_div_busy_o = w_div_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_div_done <= 1'b0;
    end else begin
      if (w_div_start) begin
        r_div_cnt <= DIV_LOAD;
      end else if (r_div_cnt != '0) begin
        r_div_cnt <= r_div_cnt - DIV_ONE;
      end
      if (r_div_cnt == DIV_ONE) begin
        r_div_done <= 1'b1;
      end else if (!fc_bk_idex_o) begin
        r_div_done <= 1'b0;
      end
    end
  end

  assign w_rs1_hit  = id_rs1_re_i && (id_rs1_raddr_i == idex_reg_waddr_i);
  assign w_rs2_hit  = id_rs2_re_i && (id_rs2_raddr_i == idex_reg_waddr_i);
  assign w_load_use = idex_mem_re_i && (idex_reg_waddr_i != '0) && (w_rs1_hit || w_rs2_hit);

  // WB is never held; a stalled MEM stage simply feeds bubbles into mem_wb.
  assign fc_bk_memwb_o = 1'b0;

  always_comb begin
    fc_bk_pc_o       = 1'b0;
    fc_bk_ifid_o     = 1'b0;
    fc_bk_idex_o     = 1'b0;
    fc_bk_exmem_o    = 1'b0;
    fc_flush_ifid_o  = 1'b0;
    fc_flush_idex_o  = 1'b0;
    fc_flush_exmem_o = 1'b0;
    fc_flush_memwb_o = 1'b0;
    if (w_timeout) begin
      fc_flush_exmem_o = 1'b1;
      fc_flush_memwb_o = 1'b1;
    end else if (w_mem_stall) begin
      fc_bk_pc_o       = 1'b1;
      fc_bk_ifid_o     = 1'b1;
      fc_bk_idex_o     = 1'b1;
      fc_bk_exmem_o    = 1'b1;
      fc_flush_memwb_o = 1'b1;
    end else if (w_div_stall) begin
      fc_bk_pc_o       = 1'b1;
      fc_bk_ifid_o     = 1'b1;
      fc_bk_idex_o     = 1'b1;
      fc_flush_exmem_o = 1'b1;
    end else if (ex_jump_i) begin
      fc_flush_ifid_o  = 1'b1;
      fc_flush_idex_o  = 1'b1;
    end else if (w_load_use) begin
      fc_bk_pc_o       = 1'b1;
      fc_bk_ifid_o     = 1'b1;
      fc_flush_idex_o  = 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed self-checking bench for flow_ctrl with DIV_CYCLES=4, BUS_TIMEOUT=4.
module tb_flow_ctrl;

  localparam int AW = 5;

  // Output vector order: bk_pc bk_ifid bk_idex bk_exmem bk_memwb
  //                      fl_ifid fl_idex fl_exmem fl_memwb div_busy bus_err
  localparam logic [10:0] NONE   = 11'b00000000000;
  localparam logic [10:0] LU     = 11'b11000010000;
  localparam logic [10:0] MEMST  = 11'b11110000100;
  localparam logic [10:0] MEMDIV = 11'b11110000110;
  localparam logic [10:0] TMO    = 11'b00000001100;
  localparam logic [10:0] ERR    = 11'b00000000001;
  localparam logic [10:0] DIV    = 11'b11100001010;
  localparam logic [10:0] JMP    = 11'b00000110000;

  // Control nibble order: mem_req mem_ack jump div_start
  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_REQ  = 4'b1000;
  localparam logic [3:0] C_ACK  = 4'b1100;
  localparam logic [3:0] C_JMP  = 4'b0010;
  localparam logic [3:0] C_DIV  = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rs1Addr = '0;
  logic          rs1Re = 1'b0;
  logic [AW-1:0] rs2Addr = '0;
  logic          rs2Re = 1'b0;
  logic          memRe = 1'b0;
  logic [AW-1:0] wAddr = '0;
  logic          jump = 1'b0;
  logic          divStart = 1'b0;
  logic          memReq = 1'b0;
  logic          memAck = 1'b0;

  logic bkPc, bkIfid, bkIdex, bkExmem, bkMemwb;
  logic flIfid, flIdex, flExmem, flMemwb, divBusy, busErr;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flow_ctrl #(
    .DIV_CYCLES  (4),
    .BUS_TIMEOUT (4),
    .REG_AW      (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_raddr_i   (rs1Addr),
    .id_rs1_re_i      (rs1Re),
    .id_rs2_raddr_i   (rs2Addr),
    .id_rs2_re_i      (rs2Re),
    .idex_mem_re_i    (memRe),
    .idex_reg_waddr_i (wAddr),
    .ex_jump_i        (jump),
    .ex_div_start_i   (divStart),
    .mem_req_i        (memReq),
    .mem_ack_i        (memAck),
    .fc_bk_pc_o       (bkPc),
    .fc_bk_ifid_o     (bkIfid),
    .fc_bk_idex_o     (bkIdex),
    .fc_bk_exmem_o    (bkExmem),
    .fc_bk_memwb_o    (bkMemwb),
    .fc_flush_ifid_o  (flIfid),
    .fc_flush_idex_o  (flIdex),
    .fc_flush_exmem_o (flExmem),
    .fc_flush_memwb_o (flMemwb),
    .fc_div_busy_o    (divBusy),
    .fc_bus_err_o     (busErr)
  );

  assign obs = {bkPc, bkIfid, bkIdex, bkExmem, bkMemwb,
                flIfid, flIdex, flExmem, flMemwb, divBusy, busErr};

  // Advance one cycle, drive new inputs just after the edge, settle before checking.
  task automatic applyStimulus(input logic [3:0] ctl, input logic ld, input logic [AW-1:0] rd,
                               input logic [AW-1:0] a1, input logic e1,
                               input logic [AW-1:0] a2, input logic e2);
    @(posedge clk);
    #1;
    {memReq, memAck, jump, divStart} = ctl;
    memRe   = ld;
    wAddr   = rd;
    rs1Addr = a1;
    rs1Re   = e1;
    rs2Addr = a2;
    rs2Re   = e2;
    #2;
  endtask

  task automatic applyCtl(input logic [3:0] ctl);
    applyStimulus(ctl, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] expected);
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expected);
    end
  endtask

  initial begin
    #3;
    checkOutput("reset_held", NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    checkOutput("reset_released", NONE);

    // Load-use hazards
    applyStimulus(C_IDLE, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    checkOutput("lu_rs1", LU);
    applyCtl(C_IDLE);
    checkOutput("lu_bubble_after", NONE);
    applyStimulus(C_IDLE, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    checkOutput("lu_rs2", LU);
    applyStimulus(C_IDLE, 1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
    checkOutput("lu_no_read_enable", NONE);
    applyStimulus(C_IDLE, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    checkOutput("lu_rd_x0", NONE);
    applyStimulus(C_IDLE, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    checkOutput("lu_not_load", NONE);

    // Bus access acked after three wait cycles
    applyCtl(C_REQ);
    checkOutput("mem_wait0", MEMST);
    applyCtl(C_REQ);
    checkOutput("mem_wait1", MEMST);
    applyCtl(C_REQ);
    checkOutput("mem_wait2", MEMST);
    applyCtl(C_ACK);
    checkOutput("mem_ack", NONE);
    applyCtl(C_IDLE);
    checkOutput("mem_after_ack", NONE);
    applyCtl(C_ACK);
    checkOutput("mem_immediate_ack", NONE);

    // Bus timeout with no ack
    for (int i = 0; i < 4; i++) begin
      applyCtl(C_REQ);
      checkOutput("tmo_wait", MEMST);
    end
    applyCtl(C_REQ);
    checkOutput("tmo_flush", TMO);
    applyCtl(C_IDLE);
    checkOutput("tmo_err_pulse", ERR);
    applyCtl(C_IDLE);
    checkOutput("tmo_err_single", NONE);

    // Ack on the timeout cycle wins
    for (int i = 0; i < 4; i++) begin
      applyCtl(C_REQ);
      checkOutput("ackt_wait", MEMST);
    end
    applyCtl(C_ACK);
    checkOutput("ackt_ack", NONE);
    applyCtl(C_IDLE);
    checkOutput("ackt_no_err", NONE);

    // Divide with start held throughout
    for (int i = 0; i < 4; i++) begin
      applyCtl(C_DIV);
      checkOutput("div_stall", DIV);
    end
    applyCtl(C_DIV);
    checkOutput("div_no_retrigger", NONE);
    applyCtl(C_IDLE);
    checkOutput("div_idle", NONE);

    // Divide started under a bus stall keeps counting
    applyCtl(C_REQ | C_DIV);
    checkOutput("memdiv_start", MEMDIV);
    applyCtl(C_ACK | C_DIV);
    checkOutput("memdiv_ack", DIV);
    applyCtl(C_DIV);
    checkOutput("memdiv_cnt2", DIV);
    applyCtl(C_DIV);
    checkOutput("memdiv_cnt1", DIV);
    applyCtl(C_DIV);
    checkOutput("memdiv_done", NONE);
    applyCtl(C_IDLE);
    checkOutput("memdiv_idle", NONE);

    // Jump held through a two-cycle bus stall
    applyCtl(C_REQ | C_JMP);
    checkOutput("jmp_under_mem0", MEMST);
    applyCtl(C_REQ | C_JMP);
    checkOutput("jmp_under_mem1", MEMST);
    applyCtl(C_ACK | C_JMP);
    checkOutput("jmp_release", JMP);
    applyCtl(C_IDLE);
    checkOutput("jmp_after", NONE);

    // Priority between jump, load-use and divide
    applyStimulus(C_JMP, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    checkOutput("jmp_over_lu", JMP);
    applyCtl(C_DIV | C_JMP);
    checkOutput("div_over_jmp", DIV);
    for (int i = 0; i < 3; i++) begin
      applyCtl(C_DIV | C_JMP);
      checkOutput("div_over_jmp_hold", DIV);
    end
    applyCtl(C_JMP);
    checkOutput("jmp_after_div", JMP);
    applyCtl(C_IDLE);
    checkOutput("prio_idle", NONE);

    // Reset asserted while the FSM sits in WAIT with wait_cnt=2
    applyCtl(C_REQ);
    checkOutput("rstw_wait0", MEMST);
    applyCtl(C_REQ);
    checkOutput("rstw_wait1", MEMST);
    @(posedge clk);
    #1;
    rst = 1'b1;
    {memReq, memAck, jump, divStart} = C_IDLE;
    #2;
    checkOutput("rstw_async_drop", NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    checkOutput("rstw_released_idle", NONE);
    applyCtl(C_IDLE);
    checkOutput("rstw_no_err", NONE);

    // Reset mid-divide, then a fresh divide runs its full length
    applyCtl(C_DIV);
    checkOutput("rstd_div0", DIV);
    applyCtl(C_DIV);
    checkOutput("rstd_div1", DIV);
    @(posedge clk);
    #1;
    rst = 1'b1;
    divStart = 1'b0;
    #2;
    checkOutput("rstd_async_drop", NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      applyCtl(C_DIV);
      checkOutput("rstd_fresh_div", DIV);
    end
    applyCtl(C_DIV);
    checkOutput("rstd_fresh_done", NONE);
    applyCtl(C_IDLE);
    checkOutput("rstd_idle", NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_ctrl.md
Name: flow_ctrl

Overview:
- Central pipeline flow controller ("fc") for the 5-stage core. Generates the block (stall) and flush strobes consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Resolves four hazard classes:
  - data-bus wait states
  - multi-cycle divide
  - taken branch/jump in EX
  - load-use dependency in ID
- Sequential content: a bus-wait FSM with timeout counter, and a divide-occupancy counter.

Parameters:
- DIV_CYCLES, 32, total cycles the divider occupies EX (>=2)
- BUS_TIMEOUT, 255, max wait cycles on the data bus before the access is abandoned (>=1)
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- id_rs1_raddr_i  in  REG_AW  ID-stage rs1 address
- id_rs1_re_i  in  1  rs1 read enable
- id_rs2_raddr_i  in  REG_AW  ID-stage rs2 address
- id_rs2_re_i  in  1  rs2 read enable
- idex_mem_re_i  in  1  instruction in EX is a load
- idex_reg_waddr_i  in  REG_AW  EX-stage destination register
- ex_jump_i  in  1  EX resolved taken branch/jump
- ex_div_start_i  in  1  EX issues a divide (level, held while idex held)
- mem_req_i  in  1  MEM stage has a load/store on the bus
- mem_ack_i  in  1  bus completes access this cycle
- fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o, fc_bk_memwb_o  out  1 each  block strobes
- fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o  out  1 each  flush strobes
- fc_div_busy_o  out  1  divider occupied
- fc_bus_err_o  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset: FSM=IDLE, wait_cnt=0, div_cnt=0, fc_bus_err_o=0. All strobes evaluate to 0 with inputs idle.
- Strobes are combinational from inputs plus registered state; zero-cycle latency.
- fc_bk_memwb_o is tied 0. The mem_wb register gives block priority over flush, so WB is never held, only bubbled.
- Bus FSM states:
  - IDLE: mem_req_i & !mem_ack_i -> WAIT, wait_cnt<=1. In the same cycle mem_stall=1.
  - WAIT, mem_ack_i=1: -> IDLE, mem_stall=0 that cycle.
  - WAIT, wait_cnt==BUS_TIMEOUT & !mem_ack_i: -> IDLE, fc_bus_err_o=1 (registered, next cycle), timeout=1 (combinational, this cycle).
  - WAIT otherwise: wait_cnt++, mem_stall=1.
  - mem_ack_i in the same cycle as timeout: ack wins, no error.
  - wait_cnt width: clog2(BUS_TIMEOUT+1); never wraps.
- Divide counter:
  - div_cnt==0 & ex_div_start_i: div_cnt<=DIV_CYCLES-1, div_stall=1.
  - div_cnt>1: div_stall=1, decrement.
  - div_cnt==1: div_stall=1, decrement to 0; the following cycle EX result is valid and div_stall=0 even though ex_div_start_i is still high (start is edge-qualified by a registered "div_done" flag, cleared when idex advances).
  - Net: DIV_CYCLES stalled cycles per divide.
  - fc_div_busy_o = (div_cnt!=0) | start-cycle.
  - Counter runs during mem_stall.
- load_use = idex_mem_re_i & idex_reg_waddr_i!=0 & ((id_rs1_re_i & rs1==waddr) | (id_rs2_re_i & rs2==waddr)).
- Priority (highest first):
  1. timeout: flush_exmem=1, flush_memwb=1, all bk=0.
  2. mem_stall: bk_pc, bk_ifid, bk_idex, bk_exmem=1; flush_memwb=1.
  3. div_stall: bk_pc, bk_ifid, bk_idex=1; flush_exmem=1.
  4. ex_jump_i: flush_ifid, flush_idex=1; pc not blocked (loads target).
  5. load_use: bk_pc, bk_ifid=1; flush_idex=1.
- A jump under a stall is not lost: EX is held, ex_jump_i stays high, and it is serviced when the stall releases.
- Reset mid-access or mid-divide: FSM/counters clear immediately; no error pulse.

Decomposition:
- Shared package (core_defines): FSM state encodings FC_IDLE/FC_WAIT, REG_AW, default DIV_CYCLES/BUS_TIMEOUT.
- One sub-module, fc_bus_wait: bus FSM plus timeout counter, producing mem_stall/timeout/err.
- Divide counter and priority mux stay in flow_ctrl.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 -> one cycle of bk_pc=bk_ifid=flush_idex=1, then all 0. Same with rd=x0 -> no stall.
- mem_req_i with ack after 3 cycles -> bk_pc..bk_exmem and flush_memwb high for 3 cycles, low on the ack cycle, FSM back to IDLE.
- BUS_TIMEOUT=4, no ack -> 4 stall cycles, then flush_exmem=flush_memwb=1, fc_bus_err_o pulses exactly 1 cycle. Ack arriving on the timeout cycle -> no error.
- Divide with DIV_CYCLES=4 while ex_div_start_i held -> exactly 4 cycles of bk_idex/flush_exmem, fc_div_busy_o for 4 cycles, no re-trigger.
- ex_jump_i during a 2-cycle mem stall -> stall strobes only; flush_ifid/flush_idex assert on the release cycle.
- Reset asserted mid-WAIT (cnt=2) -> outputs drop asynchronously, FSM=IDLE, no bus_err.
